// File: rtl/reg_writeback_queue_pkg.sv
// Shared register-file geometry for the writeback path.
// Module parameters take their defaults from these values.
package reg_writeback_queue_pkg;
    localparam int unsigned REG_DATA_WIDTH = 20;
    localparam int unsigned REG_ADDR_WIDTH = 4;
    localparam int unsigned NUM_REGS       = 16;
endpackage

// File: rtl/reg_writeback_queue_wb_fwd_match.sv
// Searches the occupied queue entries for a read address.
// On a hit it returns the youngest matching value.
module wb_fwd_match
    import reg_writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data_i,
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [$clog2(DEPTH)-1:0]         tail_i,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic                             hit_o,
    output logic [DATA_WIDTH-1:0]            data_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk backwards from the newest slot (tail-1); the first match is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail_i - PW'(1) - PW'(k);
            if (!hit_o && valid_i[idx] && (entry_addr_i[idx] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[idx];
            end
        end
    end
endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register-file write port,
// with forwarding of pending values to the two operand read ports.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_wr_valid,
    input  logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]    mem_wr_data,
    input  logic                     alu_wr_valid,
    input  logic [ADDR_WIDTH-1:0]    alu_wr_addr,
    input  logic [DATA_WIDTH-1:0]    alu_wr_data,
    output logic                     wb_ready,
    output logic [ADDR_WIDTH-1:0]    RegWriteAdress,
    output logic [DATA_WIDTH-1:0]    WriteData,
    output logic                     WriteEnable,
    input  logic [ADDR_WIDTH-1:0]    rd_addr1,
    input  logic [ADDR_WIDTH-1:0]    rd_addr2,
    output logic                     fwd_hit1,
    output logic [DATA_WIDTH-1:0]    fwd_data1,
    output logic                     fwd_hit2,
    output logic [DATA_WIDTH-1:0]    fwd_data2,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]                    head_q, head_d;
    logic [PW-1:0]                    tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;

    logic          not_empty;
    logic [CW:0]   space;
    logic          mem_take;
    logic          alu_take;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] age;
    logic [DEPTH-1:0] valid_mask;

    // The head slot frees on this edge, so it counts toward space when occupied.
    always_comb begin
        not_empty = (count_q != '0);
        space     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(not_empty);
        wb_ready  = (space >= (CW+1)'(2));
        mem_take  = wb_ready & mem_wr_valid;
        alu_take  = wb_ready & alu_wr_valid;

        addr_d   = addr_q;
        data_d   = data_q;
        alu_slot = tail_q + PW'(mem_take);
        if (mem_take) begin
            addr_d[tail_q] = mem_wr_addr;
            data_d[tail_q] = mem_wr_data;
        end
        if (alu_take) begin
            addr_d[alu_slot] = alu_wr_addr;
            data_d[alu_slot] = alu_wr_data;
        end
        tail_d  = tail_q + PW'(mem_take) + PW'(alu_take);
        head_d  = head_q + PW'(not_empty);
        count_d = count_q + CW'(mem_take) + CW'(alu_take) - CW'(not_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        valid_mask = '0;
        age        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age           = PW'(i) - head_q;
            valid_mask[i] = ({1'b0, age} < count_q);
        end
    end

    assign WriteEnable    = not_empty;
    assign RegWriteAdress = not_empty ? addr_q[head_q] : '0;
    assign WriteData      = not_empty ? data_q[head_q] : '0;
    assign queue_count    = count_q;

    wb_fwd_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd1 (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .valid_i      (valid_mask),
        .tail_i       (tail_q),
        .rd_addr_i    (rd_addr1),
        .hit_o        (fwd_hit1),
        .data_o       (fwd_data1)
    );

    wb_fwd_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd2 (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .valid_i      (valid_mask),
        .tail_i       (tail_q),
        .rd_addr_i    (rd_addr2),
        .hit_o        (fwd_hit2),
        .data_o       (fwd_data2)
    );
endmodule
